// File: rtl/fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage: next-PC select
//   encodings driven by the decode stage, the IF/ID bubble word, the fetch
//   controller state type and a word-alignment helper.
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

    // Next-PC select, as produced by the decode stage.
    typedef enum logic [1:0] {
        PC_4   = 2'd0,
        PC_BEQ = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } npc_sel_e;

    // sll $0,$0,0 -- the architectural no-op inserted as a bubble.
    localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;

    // Fetch controller states.
    //   S_REQ  : request outstanding to instruction memory
    //   S_HOLD : word returned but IF/ID stalled; word parked in skid buffer
    //   S_DROP : redirected while a request was outstanding; response discarded
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    // Every PC load is forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register with write enable, flush and asynchronous
//   active-low reset. Flush has priority over a load: it inserts the bubble
//   word, clears valid and keeps the previously held pc4.
//
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   we_i     in   load instr_i/pc4_i and mark valid
//   flush_i  in   load bubble (priority over we_i)
//   instr_i  in   instruction word to load
//   pc4_i    in   PC+4 of that instruction
//   instr_o  out  held instruction
//   pc4_o    out  held PC+4
//   valid_o  out  held instruction is real (not a bubble)
// ----------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= INSTR_BUBBLE;
            valid_q <= 1'b0;
        end else if (we_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with a single-outstanding-request memory port,
//   a one-entry skid buffer for IF/ID stalls and redirect handling for
//   branches/jumps resolved in decode.
//
//   clock          in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   pc_write       in   PC may update this cycle (also gates redirects)
//   if_id_write    in   IF/ID may load this cycle
//   if_id_flush    in   IF/ID loads a bubble
//   s_npc          in   next-PC select (npc_sel_e)
//   zero           in   branch-equal result for PC_BEQ
//   branch_target  in   PC_BEQ target
//   jump_target    in   PC_J target
//   jr_target      in   PC_JR target
//   imem_req       out  instruction memory request
//   imem_addr      out  fetch address
//   imem_ready     in   response for the outstanding request this cycle
//   imem_rdata     in   instruction word
//   pc             out  current fetch PC
//   if_id_instr    out  IF/ID instruction (0 = bubble)
//   if_id_pc4      out  IF/ID PC+4
//   if_id_valid    out  IF/ID holds a real instruction
//   fetch_busy     out  waiting on memory (S_REQ without ready, or S_DROP)
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        if_id_flush,
    input  logic [1:0]  s_npc,
    input  logic        zero,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc4_q, skid_pc4_d;
    logic [31:0]  drop_addr_q, drop_addr_d;

    logic [31:0]  pc_plus4;
    logic         redirect;
    logic [31:0]  redirect_target;
    logic         id_we;
    logic [31:0]  id_instr;
    logic [31:0]  id_pc4;
    logic         busy_c;

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect decode; pc_write gates every redirect.
    always_comb begin
        redirect        = 1'b0;
        redirect_target = pc_q;
        case (npc_sel_e'(s_npc))
            PC_BEQ: begin
                redirect        = pc_write & zero;
                redirect_target = branch_target;
            end
            PC_J: begin
                redirect        = pc_write;
                redirect_target = jump_target;
            end
            PC_JR: begin
                redirect        = pc_write;
                redirect_target = jr_target;
            end
            default: begin
                redirect        = 1'b0;
                redirect_target = pc_q;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        drop_addr_d  = drop_addr_q;
        id_we        = 1'b0;
        id_instr     = imem_rdata;
        id_pc4       = pc_plus4;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        busy_c       = 1'b0;

        case (state_q)
            S_REQ: begin
                imem_req = 1'b1;
                busy_c   = ~imem_ready;
                if (redirect) begin
                    pc_d = word_align(redirect_target);
                    if (!imem_ready) begin
                        // Response still owed for pc_q: remember its address
                        // so the port stays stable until it is consumed.
                        state_d     = S_DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (imem_ready) begin
                    if (if_id_write) begin
                        id_we = 1'b1;
                        if (pc_write) begin
                            pc_d = word_align(pc_plus4);
                        end
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                id_instr = skid_instr_q;
                id_pc4   = skid_pc4_q;
                if (redirect) begin
                    // Buffered word is on the wrong path; leaving S_HOLD
                    // invalidates it.
                    pc_d    = word_align(redirect_target);
                    state_d = S_REQ;
                end else if (if_id_write) begin
                    id_we   = 1'b1;
                    state_d = S_REQ;
                    if (pc_write) begin
                        pc_d = word_align(pc_plus4);
                    end
                end
            end

            S_DROP: begin
                imem_addr = drop_addr_q;
                busy_c    = 1'b1;
                if (redirect) begin
                    pc_d = word_align(redirect_target);
                end
                if (imem_ready) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ;
            pc_q         <= word_align(RESET_PC);
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            drop_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            drop_addr_q  <= drop_addr_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i   (clock),
        .rst_ni  (reset),
        .we_i    (id_we),
        .flush_i (if_id_flush),
        .instr_i (id_instr),
        .pc4_i   (id_pc4),
        .instr_o (if_id_instr),
        .pc4_o   (if_id_pc4),
        .valid_o (if_id_valid)
    );

    assign pc = pc_q;
    // Busy is held low while reset is asserted, whatever imem_ready does.
    assign fetch_busy = reset & busy_c;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clock;
    logic        reset;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic [1:0]  s_npc;
    logic        zero;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_busy;

    logic        mem_auto;
    logic        man_ready;

    int checks;
    int failures;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .s_npc         (s_npc),
        .zero          (zero),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .fetch_busy    (fetch_busy)
    );

    // Instruction memory content: a recognisable word per address.
    function automatic logic [31:0] mword(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    // Zero-wait memory when mem_auto, otherwise ready is driven by hand.
    always_comb begin
        imem_ready = mem_auto ? imem_req : man_ready;
        imem_rdata = mword(imem_addr);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_defaults();
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        s_npc         = PC_4;
        zero          = 1'b0;
        branch_target = '0;
        jump_target   = '0;
        jr_target     = '0;
        mem_auto      = 1'b1;
        man_ready     = 1'b0;
    endtask

    task automatic reset_dut();
        set_defaults();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_defaults();
        reset = 1'b0;
        tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (if_id_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=%h", if_id_instr, 32'h0); end
        checks++; if (if_id_pc4 !== 32'h0) begin failures++; $display("FAIL rst_pc4 got=%h exp=%h", if_id_pc4, 32'h0); end
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
        checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", fetch_busy); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rst_first_req got=%b/%h exp=1/%h", imem_req, imem_addr, 32'h0); end
    endtask

    task automatic test_sequential();
        reset_dut();
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (if_id_pc4 !== 32'(4 * k) || if_id_instr !== mword(32'(4 * (k - 1))) || if_id_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq_%0d got=%h/%h/%b exp=%h/%h/1", k, if_id_pc4, if_id_instr, if_id_valid, 32'(4 * k), mword(32'(4 * (k - 1))));
            end
        end
        checks++; if (pc !== 32'hC) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'hC); end
    endtask

    task automatic test_stall();
        reset_dut();
        tick();
        tick();
        if_id_write = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req got=%b exp=0", imem_req); end
        checks++; if (pc !== 32'h8) begin failures++; $display("FAIL hold_pc got=%h exp=%h", pc, 32'h8); end
        checks++; if (if_id_pc4 !== 32'h8 || fetch_busy !== 1'b0) begin failures++; $display("FAIL hold_ifid got=%h/%b exp=%h/0", if_id_pc4, fetch_busy, 32'h8); end
        tick();
        tick();
        checks++; if (pc !== 32'h8 || imem_req !== 1'b0) begin failures++; $display("FAIL hold3_pc got=%h/%b exp=%h/0", pc, imem_req, 32'h8); end
        if_id_write = 1'b1;
        tick();
        checks++; if (if_id_instr !== mword(32'h8) || if_id_pc4 !== 32'hC) begin failures++; $display("FAIL release_ifid got=%h/%h exp=%h/%h", if_id_instr, if_id_pc4, mword(32'h8), 32'hC); end
        checks++; if (pc !== 32'hC || imem_req !== 1'b1) begin failures++; $display("FAIL release_pc got=%h/%b exp=%h/1", pc, imem_req, 32'hC); end
    endtask

    task automatic test_hold_redirect();
        if_id_write = 1'b0;
        tick();
        s_npc       = PC_J;
        jump_target = 32'h80;
        if_id_write = 1'b1;
        tick();
        s_npc = PC_4;
        #1;
        checks++; if (pc !== 32'h80 || imem_addr !== 32'h80) begin failures++; $display("FAIL holdredir_pc got=%h/%h exp=%h", pc, imem_addr, 32'h80); end
        checks++; if (if_id_instr !== mword(32'h8) || if_id_pc4 !== 32'hC) begin failures++; $display("FAIL holdredir_ifid got=%h/%h exp=%h/%h", if_id_instr, if_id_pc4, mword(32'h8), 32'hC); end
        tick();
        checks++; if (if_id_instr !== mword(32'h80) || if_id_pc4 !== 32'h84) begin failures++; $display("FAIL holdredir_next got=%h/%h exp=%h/%h", if_id_instr, if_id_pc4, mword(32'h80), 32'h84); end
    endtask

    task automatic test_drop();
        reset_dut();
        repeat (4) tick();
        mem_auto  = 1'b0;
        man_ready = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h10 || fetch_busy !== 1'b1) begin failures++; $display("FAIL drop_wait got=%h/%b exp=%h/1", imem_addr, fetch_busy, 32'h10); end
        tick();
        s_npc       = PC_J;
        jump_target = 32'h40;
        tick();
        s_npc = PC_4;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h10) begin failures++; $display("FAIL drop_port got=%b/%h exp=0/%h", imem_req, imem_addr, 32'h10); end
        checks++; if (pc !== 32'h40 || fetch_busy !== 1'b1) begin failures++; $display("FAIL drop_pc got=%h/%b exp=%h/1", pc, fetch_busy, 32'h40); end
        tick();
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL drop_refetch got=%b/%h exp=1/%h", imem_req, imem_addr, 32'h40); end
        checks++; if (if_id_instr !== mword(32'hC) || if_id_pc4 !== 32'h10) begin failures++; $display("FAIL drop_discard got=%h/%h exp=%h/%h", if_id_instr, if_id_pc4, mword(32'hC), 32'h10); end
        mem_auto = 1'b1;
        tick();
        checks++; if (if_id_instr !== mword(32'h40) || if_id_pc4 !== 32'h44) begin failures++; $display("FAIL drop_next got=%h/%h exp=%h/%h", if_id_instr, if_id_pc4, mword(32'h40), 32'h44); end
    endtask

    task automatic test_branch();
        reset_dut();
        s_npc         = PC_BEQ;
        zero          = 1'b0;
        branch_target = 32'h100;
        tick();
        checks++; if (pc !== 32'h4 || if_id_pc4 !== 32'h4) begin failures++; $display("FAIL beq_nt got=%h/%h exp=%h/%h", pc, if_id_pc4, 32'h4, 32'h4); end
        zero = 1'b1;
        tick();
        checks++; if (pc !== 32'h100 || if_id_pc4 !== 32'h4) begin failures++; $display("FAIL beq_t got=%h/%h exp=%h/%h", pc, if_id_pc4, 32'h100, 32'h4); end
        s_npc     = PC_JR;
        zero      = 1'b0;
        jr_target = 32'h203;
        tick();
        checks++; if (pc !== 32'h200) begin failures++; $display("FAIL jr_align got=%h exp=%h", pc, 32'h200); end
        s_npc       = PC_J;
        jump_target = 32'h300;
        pc_write    = 1'b0;
        tick();
        checks++; if (pc !== 32'h200 || if_id_instr !== mword(32'h200) || if_id_pc4 !== 32'h204) begin failures++; $display("FAIL pcw_block got=%h/%h/%h exp=%h/%h/%h", pc, if_id_instr, if_id_pc4, 32'h200, mword(32'h200), 32'h204); end
        pc_write = 1'b1;
        s_npc    = PC_4;
    endtask

    task automatic test_flush();
        if_id_flush = 1'b1;
        tick();
        if_id_flush = 1'b0;
        checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc4 !== 32'h204) begin failures++; $display("FAIL flush got=%h/%b/%h exp=%h/0/%h", if_id_instr, if_id_valid, if_id_pc4, 32'h0, 32'h204); end
    endtask

    task automatic test_wrap();
        s_npc       = PC_J;
        jump_target = 32'hFFFF_FFFC;
        tick();
        s_npc = PC_4;
        tick();
        checks++; if (pc !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_instr !== mword(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap got=%h/%h/%h exp=%h/%h/%h", pc, if_id_pc4, if_id_instr, 32'h0, 32'h0, mword(32'hFFFF_FFFC)); end
    endtask

    task automatic test_reset_mid();
        s_npc       = PC_J;
        jump_target = 32'h20;
        tick();
        s_npc     = PC_4;
        mem_auto  = 1'b0;
        man_ready = 1'b0;
        tick();
        checks++; if (pc !== 32'h20 || fetch_busy !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%h/%b exp=%h/1", pc, fetch_busy, 32'h20); end
        reset = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || fetch_busy !== 1'b0) begin failures++; $display("FAIL midrst_async got=%h/%b/%h/%h/%b exp=0/0/0/0/0", pc, if_id_valid, if_id_instr, if_id_pc4, fetch_busy); end
        tick();
        reset    = 1'b1;
        mem_auto = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL midrst_release got=%b/%h exp=1/%h", imem_req, imem_addr, 32'h0); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        set_defaults();
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_hold_redirect();
        test_drop();
        test_branch();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
